button_poll_ctrl: RTL
=====================

# button_poll_ctrl

Polling controller for the push-button PIO. It acts as an Avalon-MM master on the button PIO's s1 port and reads address 0 every POLL_DIV clocks. Each button bit is debounced with a per-bit sample counter, and press edges are latched into a write-1-to-clear edge register. An Avalon-MM slave exposes the state, edge, mask and control registers to the Nios II, and a level IRQ is raised on unmasked edges.

## Interface
- WIDTH, 4: number of button bits sampled from pio_readdata[WIDTH-1:0].
- POLL_DIV, 50000: clocks between poll sequences (1 ms at 50 MHz); legal range ≥ 4.
- DEBOUNCE_SAMPLES, 8: consecutive differing polls required to flip a stable bit; legal range 1..255.
- PRESS_LOW, 1: 1 = a button reads 0 when pressed (DE2 KEY); 0 = reads 1 when pressed.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- pio_address  out  2  address to button PIO s1.
- pio_readdata  in  32  PIO readdata; registered in the PIO, valid one clock after pio_address.
- address  in  2  slave register select.
- chipselect  in  1  slave access qualifier.
- write_n  in  1  active-low write strobe; read when chipselect=1 and write_n=1.
- writedata  in  32  slave write data.
- readdata  out  32  slave read data; registered.
- irq  out  1  level interrupt.

## Operation
- The FSM has four states: IDLE → ADDR → CAPTURE → UPDATE → IDLE.
- IDLE:
  - The poll timer counts 0..POLL_DIV-1 while enable=1.
  - At count POLL_DIV-1 the timer wraps to 0 and the FSM goes to ADDR.
  - While enable=0, the timer is held at 0.
- ADDR: pio_address=0. In every other state pio_address=3, which is unmapped and reads 0.
- CAPTURE: sample ← pio_readdata[WIDTH-1:0].
- UPDATE, per bit i:
  - If sample[i]==stable[i]: cnt[i] ← 0.
  - Else if cnt[i]==DEBOUNCE_SAMPLES-1: stable[i] ← sample[i] and cnt[i] ← 0.
  - Else: cnt[i] ← cnt[i]+1.
  - A flip of stable[i] into the pressed level sets edge[i]. A flip into the released level sets nothing.
- Clearing enable mid-sequence does not abort it. ADDR/CAPTURE/UPDATE always complete.
- Register map (32-bit, unused bits read 0):
  - 0 STATE (RO): stable[WIDTH-1:0].
  - 1 EDGE (W1C): edge bits; writing 1 clears, writing 0 has no effect.
  - 2 MASK (RW): irq mask.
  - 3 CTRL (RW): bit0 enable.
- Writes to RO registers are ignored.
- irq = |(edge & mask), driven combinationally from registers.
- Simultaneous W1C clear and hardware set of the same edge bit: the set wins and the bit stays 1.
- Reset values:
  - stable: all ones if PRESS_LOW=1, else all zeros (released).
  - cnt=0, sample=released level, edge=0, mask=0, enable=1.
  - timer=0, FSM=IDLE, pio_address=3, readdata=0, irq=0.
- Reset asserted mid-sequence returns everything to reset values immediately. No partial update may survive reset.

## Timing
- Slave read: readdata is valid the clock after chipselect&write_n is sampled high. When not reading, readdata holds its last value.
- Slave write: the register updates at the clock edge where chipselect&!write_n is sampled.
- Poll period is exactly POLL_DIV clocks. A sequence starts on every timer wrap and its ADDR…UPDATE tail fits inside the next period because POLL_DIV ≥ 4.
- Sample latency: ADDR at cycle t, CAPTURE latches the PIO value at t+1, stable/edge update at t+2, irq asserts at t+2 (combinational from edge).
- Debounce latency: an input held at a new level flips stable on the DEBOUNCE_SAMPLES-th consecutive poll that sees it.
- A single poll agreeing with stable resets that bit's count, so glitches shorter than DEBOUNCE_SAMPLES polls never change stable.

## Test plan
Bench parameters: POLL_DIV=4, DEBOUNCE_SAMPLES=3, WIDTH=4, PRESS_LOW=1, with a PIO model of 1-clock registered readdata.

- **Reset:** after reset, read STATE → 0xF, EDGE → 0, CTRL → 1, irq=0. Assert reset_n=0 mid-UPDATE → all outputs return to reset values within the same cycle.
- **Clean press:** in_port 0xF→0xE held; STATE reads 0xE after the 3rd poll (12 clocks). EDGE=0x1. irq stays 0 until MASK=0x1 is written, then irq=1. Write EDGE=0x1 → EDGE=0, irq=0.
- **Glitch rejection:** bit1 pulled low for 2 polls, then high → STATE stays 0xF, EDGE=0.
- **Release:** after a press on bit2, release and hold high 3 polls → STATE bit2=1, EDGE bit2 unchanged (no release edge).
- **Set/clear collision:** W1C of bit0 in the same cycle that UPDATE sets edge[0] → EDGE bit0 reads 1 afterward.
- **Enable:** write CTRL=0, change in_port → no pio_address=0 cycles and STATE frozen. Write CTRL=1 → polling resumes after exactly POLL_DIV clocks.

Source files
------------

// File: rtl/button_poll_ctrl.sv
// rtl/button_poll_ctrl.sv - push-button PIO poller with per-bit debounce, W1C edge latch and masked irq
module button_poll_ctrl #(
  parameter int WIDTH            = 4,
  parameter int POLL_DIV         = 50000,
  parameter int DEBOUNCE_SAMPLES = 8,
  parameter int PRESS_LOW        = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  pio_address,
  input  logic [31:0] pio_readdata,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int              TW         = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'(POLL_DIV - 1);
  localparam logic [7:0]      CNT_LAST   = 8'(DEBOUNCE_SAMPLES - 1);
  localparam logic [WIDTH-1:0] RELEASED  = {WIDTH{(PRESS_LOW != 0)}};

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_CAPTURE, S_UPDATE} state_t;

  state_t            state;
  logic [TW-1:0]     timer;
  logic              enable;
  logic [WIDTH-1:0]  sample;
  logic [WIDTH-1:0]  stable;
  logic [7:0]        cnt      [WIDTH];
  logic [7:0]        next_cnt [WIDTH];
  logic [WIDTH-1:0]  next_stable;
  logic [WIDTH-1:0]  edge_set;
  logic [WIDTH-1:0]  edge_hw;
  logic [WIDTH-1:0]  edge_clr;
  logic [WIDTH-1:0]  edge_r;
  logic [WIDTH-1:0]  mask;
  logic [31:0]       rd_mux;
  logic              wr_en;
  logic              rd_en;
  logic              unused_bits;

  assign unused_bits = ^{pio_readdata[31:WIDTH], writedata[31:WIDTH]};

  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect & write_n;

  // Debounce step for every bit, applied only in UPDATE; a flip into the pressed level raises an edge.
  always_comb begin
    next_stable = stable;
    edge_set    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      next_cnt[i] = cnt[i];
      if (sample[i] == stable[i]) begin
        next_cnt[i] = 8'd0;
      end else if (cnt[i] == CNT_LAST) begin
        next_stable[i] = sample[i];
        next_cnt[i]    = 8'd0;
        if (sample[i] != RELEASED[i]) begin
          edge_set[i] = 1'b1;
        end
      end else begin
        next_cnt[i] = cnt[i] + 8'd1;
      end
    end
  end

  assign edge_hw  = (state == S_UPDATE) ? edge_set : '0;
  assign edge_clr = (wr_en && address == 2'd1) ? writedata[WIDTH-1:0] : '0;

  // Free-running poll timer plus the ADDR/CAPTURE/UPDATE sequencer; a started sequence always completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      timer       <= '0;
      pio_address <= 2'd3;
      sample      <= RELEASED;
      stable      <= RELEASED;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= 8'd0;
      end
    end else begin
      if (!enable || timer == TIMER_LAST) begin
        timer <= '0;
      end else begin
        timer <= timer + TW'(1);
      end
      case (state)
        S_IDLE: begin
          if (enable && timer == TIMER_LAST) begin
            state       <= S_ADDR;
            pio_address <= 2'd0;
          end
        end
        S_ADDR: begin
          state       <= S_CAPTURE;
          pio_address <= 2'd3;
        end
        S_CAPTURE: begin
          sample <= pio_readdata[WIDTH-1:0];
          state  <= S_UPDATE;
        end
        S_UPDATE: begin
          stable <= next_stable;
          cnt    <= next_cnt;
          state  <= S_IDLE;
        end
        default: begin
          state       <= S_IDLE;
          pio_address <= 2'd3;
        end
      endcase
    end
  end

  // Register read selection; unused upper bits read as zero.
  always_comb begin
    rd_mux = 32'd0;
    case (address)
      2'd0:    rd_mux = 32'(stable);
      2'd1:    rd_mux = 32'(edge_r);
      2'd2:    rd_mux = 32'(mask);
      default: rd_mux = {31'd0, enable};
    endcase
  end

  // Slave register file; a hardware edge set overrides a same-cycle W1C clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_r   <= '0;
      mask     <= '0;
      enable   <= 1'b1;
      readdata <= 32'd0;
    end else begin
      edge_r <= (edge_r & ~edge_clr) | edge_hw;
      if (wr_en && address == 2'd2) begin
        mask <= writedata[WIDTH-1:0];
      end
      if (wr_en && address == 2'd3) begin
        enable <= writedata[0];
      end
      if (rd_en) begin
        readdata <= rd_mux;
      end
    end
  end

  assign irq = |(edge_r & mask);

endmodule
